// File: rtl/id_scan_ctrl_pkg.sv
// Shared definitions for the identifier scanner: ASCII class bounds,
// char-class state encoding and the class transition function.
package id_scan_ctrl_pkg;

  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_9 = 8'h39;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_UZ = 8'h5A;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LZ = 8'h7A;

  typedef enum logic [1:0] {
    CLS_IDLE  = 2'd0,
    CLS_ALPHA = 2'd1,
    CLS_DIGIT = 2'd2
  } cls_e;

  function automatic logic is_digit(logic [7:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

  function automatic logic is_letter(logic [7:0] c);
    return ((c >= ASC_UA) && (c <= ASC_UZ)) || ((c >= ASC_LA) && (c <= ASC_LZ));
  endfunction

  function automatic logic is_alnum(logic [7:0] c);
    return is_digit(c) || is_letter(c);
  endfunction

  // A digit only promotes to DIGIT once a letter has been seen in the token.
  function automatic cls_e cls_next(cls_e s, logic [7:0] c);
    cls_e n;
    n = s;
    if (is_letter(c))     n = CLS_ALPHA;
    else if (is_digit(c)) n = (s == CLS_IDLE) ? CLS_IDLE : CLS_DIGIT;
    return n;
  endfunction

endpackage

// File: rtl/id_scan_ctrl_class_fsm.sv
// Char-class FSM: advances on each alnum char (step), returns to IDLE on clear.
module id_class_fsm
  import id_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       clear,
  input  logic [7:0] ch,
  output logic [1:0] state
);

  cls_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step)  state_d = cls_next(state_q, ch);
    if (clear) state_d = CLS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLS_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/id_scan_ctrl.sv
// Identifier scanner: char FIFO -> tokenizer -> held descriptor output.
// Optional STATS_EN adds the id_count port counting accepted identifier tokens.
module id_scan_ctrl
  import id_scan_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [IDX_W-1:0] tok_start,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_is_id
`ifdef STATS_EN
  ,
  output logic [15:0]      id_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // FIFO
  logic [8:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [7:0]       head_char;
  logic             head_last;

  assign in_ready  = rst_n && (count_q != CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (count_q != '0) && !(tok_valid_q && !tok_ready);
  assign head_char = mem_q[rd_ptr_q][7:0];
  assign head_last = mem_q[rd_ptr_q][8];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_char};
  end

  // Tokenizer state and descriptor register
  logic [IDX_W-1:0] idx_q, idx_d, start_q, start_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_tok_q, in_tok_d;
  logic             tok_valid_q, tok_valid_d;
  logic [IDX_W-1:0] tok_start_q, tok_start_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             tok_is_id_q, tok_is_id_d;
  logic             alnum, cls_step, cls_clear;
  logic [1:0]       cls_state;
  cls_e             cls_post;

  assign alnum    = is_alnum(head_char);
  assign cls_post = alnum ? cls_next(cls_e'(cls_state), head_char) : cls_e'(cls_state);

  id_class_fsm u_cls (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (cls_step),
    .clear (cls_clear),
    .ch    (head_char),
    .state (cls_state)
  );

  always_comb begin
    idx_d       = idx_q;
    start_d     = start_q;
    len_d       = len_q;
    in_tok_d    = in_tok_q;
    tok_valid_d = tok_valid_q && !tok_ready;
    tok_start_d = tok_start_q;
    tok_len_d   = tok_len_q;
    tok_is_id_d = tok_is_id_q;
    cls_step    = 1'b0;
    cls_clear   = 1'b0;
    if (pop) begin
      cls_step = alnum;
      if (alnum) begin
        if (!in_tok_q) begin
          start_d  = idx_q;
          len_d    = LEN_W'(1);
          in_tok_d = 1'b1;
        end else if (len_q != LEN_MAX) begin
          len_d = len_q + LEN_W'(1);
        end
      end
      // An alnum last char joins the token before it is flushed.
      if ((alnum || in_tok_q) && (head_last || !alnum)) begin
        tok_valid_d = 1'b1;
        tok_start_d = start_d;
        tok_len_d   = len_d;
        tok_is_id_d = (cls_post == CLS_DIGIT);
        in_tok_d    = 1'b0;
        cls_clear   = 1'b1;
      end
      if (head_last) cls_clear = 1'b1;
      idx_d = head_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      start_q     <= '0;
      len_q       <= '0;
      in_tok_q    <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_start_q <= '0;
      tok_len_q   <= '0;
      tok_is_id_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      len_q       <= len_d;
      in_tok_q    <= in_tok_d;
      tok_valid_q <= tok_valid_d;
      tok_start_q <= tok_start_d;
      tok_len_q   <= tok_len_d;
      tok_is_id_q <= tok_is_id_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_start = tok_start_q;
  assign tok_len   = tok_len_q;
  assign tok_is_id = tok_is_id_q;

`ifdef STATS_EN
  logic [15:0] id_count_q, id_count_d;

  always_comb begin
    id_count_d = id_count_q;
    if (tok_valid_q && tok_ready && tok_is_id_q) id_count_d = id_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) id_count_q <= '0;
    else        id_count_q <= id_count_d;
  end

  assign id_count = id_count_q;
`endif

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Bench for id_scan_ctrl: directed streams plus random streams, scored against
// a token-level reference model (identifier = token ending in a digit that contains a letter).
module tb_id_scan_ctrl;
  localparam int DEPTH = 8;
  localparam int IDX_W = 8;
  localparam int LEN_W = 4;
  localparam int LMAX  = (1 << LEN_W) - 1;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, tok_ready = 1'b0;
  logic [7:0]       in_char = 8'h00;
  logic             in_ready, tok_valid, tok_is_id;
  logic [IDX_W-1:0] tok_start;
  logic [LEN_W-1:0] tok_len;
`ifdef STATS_EN
  logic [15:0]      id_count;
`endif

  id_scan_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_start (tok_start),
    .tok_len   (tok_len),
    .tok_is_id (tok_is_id)
`ifdef STATS_EN
    ,
    .id_count  (id_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] c; logic l;} ch_t;
  typedef struct {int s; int n; bit id;} desc_t;

  ch_t   pend[$];
  desc_t expq[$];
  int    checks = 0, errors = 0;
  int    m_idx = 0, m_start = 0, m_len = 0, ids_acc = 0;
  bit    m_in = 0, m_letter = 0, m_dig = 0, force_valid = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit t_letter(logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction
  function automatic bit t_digit(logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  // Reference: tokens are maximal alnum runs inside a stream; index counts chars per stream.
  task automatic model_push(ch_t x);
    bit an;
    an = t_letter(x.c) || t_digit(x.c);
    if (an) begin
      if (!m_in) begin
        m_start = m_idx; m_len = 0; m_letter = 0; m_in = 1;
      end
      if (m_len < LMAX) m_len++;
      if (t_letter(x.c)) m_letter = 1;
      m_dig = t_digit(x.c);
    end
    if (m_in && (x.l || !an)) begin
      expq.push_back('{m_start, m_len, m_letter && m_dig});
      m_in = 0;
    end
    m_idx = x.l ? 0 : (m_idx + 1) % (1 << IDX_W);
  endtask

  task automatic model_reset();
    pend.delete(); expq.delete();
    m_idx = 0; m_in = 0; m_len = 0; ids_acc = 0;
  endtask

  task automatic add_str(string s, bit last_at_end);
    for (int i = 0; i < s.len(); i++) pend.push_back('{s[i], last_at_end && (i == s.len() - 1)});
  endtask

  // rmode: 0 never ready, 1 always ready, 2 random
  task automatic cycle(int rmode);
    desc_t d;
    @(negedge clk);
    in_valid = (pend.size() > 0) && (force_valid || $urandom_range(0, 3) != 0);
    if (pend.size() > 0) begin
      in_char = pend[0].c; in_last = pend[0].l;
    end
    tok_ready = (rmode == 1) ? 1'b1 : (rmode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (in_valid && in_ready) begin
      model_push(pend[0]);
      void'(pend.pop_front());
    end
    if (tok_valid && tok_ready) begin
      if (expq.size() == 0) chk("extra_desc", 1, 0);
      else begin
        d = expq.pop_front();
        chk("tok_start", int'(tok_start), d.s);
        chk("tok_len", int'(tok_len), d.n);
        chk("tok_is_id", int'(tok_is_id), int'(d.id));
        if (d.id) ids_acc++;
      end
    end
  endtask

  task automatic drain(string tag, int rmode);
    int n;
    n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < 5000) begin
      cycle(rmode);
      n++;
    end
    chk({tag, "_drained"}, int'(n < 5000), 1);
    repeat (6) cycle(1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_tok_valid"}, int'(tok_valid), 0);
    chk({tag, "_tok_start"}, int'(tok_start), 0);
    chk({tag, "_tok_len"}, int'(tok_len), 0);
    chk({tag, "_tok_is_id"}, int'(tok_is_id), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
`ifdef STATS_EN
    chk({tag, "_id_count"}, int'(id_count), 0);
`endif
  endtask

  initial begin
    string cs;
    string s;
    cs = "ab9Z0 ;_xQ7";
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    add_str("ab12 ", 1);
    drain("t1", 1);

    add_str("12a;1a2", 1);
    add_str("ab ", 1);
    drain("t2", 2);

    // Back-pressure: descriptor held while the FIFO fills behind it
    force_valid = 1;
    add_str("x9 yzzzzzzzzzzzz ", 1);
    repeat (30) cycle(0);
    chk("t3_tok_valid", int'(tok_valid), 1);
    chk("t3_in_ready", int'(in_ready), 0);
    chk("t3_start", int'(tok_start), expq[0].s);
    chk("t3_len", int'(tok_len), expq[0].n);
    chk("t3_is_id", int'(tok_is_id), int'(expq[0].id));
    repeat (5) cycle(0);
    chk("t3_len_stable", int'(tok_len), 2);
    force_valid = 0;
    drain("t3", 2);

    s = "";
    for (int i = 0; i < 20; i++) s = {s, "a"};
    add_str({s, "5 "}, 1);
    drain("t4", 2);

    add_str("abc", 0);
    repeat (6) cycle(1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_zero("t5_reset");
    rst_n = 1'b1;
    model_reset();
    add_str("q7 ", 1);
    drain("t5", 1);

    add_str("a1 b c2 ", 1);
    drain("t6", 1);

    for (int k = 0; k < 8; k++) begin
      int n;
      n = (k == 7) ? 300 : $urandom_range(5, 40);
      for (int i = 0; i < n; i++)
        pend.push_back('{cs[$urandom_range(0, cs.len() - 1)], (i == n - 1) && (k != 7 || $urandom_range(0, 1) == 1)});
    end
    drain("rand", 2);

`ifdef STATS_EN
    chk("id_count", int'(id_count), ids_acc % 65536);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
